// File: rtl/inst_order_merge_pkg.sv
// inst_order_merge_pkg: shared widths and the fetch_entry_t {inst, addr, pid} record
package inst_order_merge_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int PID_W = 2;
  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic [PID_W-1:0] pid;
  } fetch_entry_t;
endpackage

// File: rtl/inst_order_merge_if.sv
// inst_order_merge_if: fetch-way inputs/readies, flush, and ordered decode output; master drives, slave is the merge
interface inst_order_merge_if;
  import inst_order_merge_pkg::*;
  logic valid_way0_i, valid_way1_i, ready_way0_o, ready_way1_o;
  logic [DATA_W-1:0] inst_way0_i, inst_way1_i, inst_o;
  logic [ADDR_W-1:0] addr_way0_i, addr_way1_i, addr_o;
  logic [PID_W-1:0] pid_way0_i, pid_way1_i, pid_o, flush_pid_i;
  logic flush_i, valid_o, ready_i, order_err_o;
  modport master (
    output valid_way0_i, inst_way0_i, addr_way0_i, pid_way0_i,
    output valid_way1_i, inst_way1_i, addr_way1_i, pid_way1_i,
    output flush_i, flush_pid_i, ready_i,
    input ready_way0_o, ready_way1_o, valid_o, inst_o, addr_o, pid_o, order_err_o
  );
  modport slave (
    input valid_way0_i, inst_way0_i, addr_way0_i, pid_way0_i,
    input valid_way1_i, inst_way1_i, addr_way1_i, pid_way1_i,
    input flush_i, flush_pid_i, ready_i,
    output ready_way0_o, ready_way1_o, valid_o, inst_o, addr_o, pid_o, order_err_o
  );
endinterface

// File: rtl/inst_order_merge_order_fifo.sv
// order_fifo: sync FIFO (clk, reset, clr flush, push/din, pop/head, count, empty); push when full dropped unless popping
module order_fifo
  import inst_order_merge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T din,
  output T head,
  output logic [$clog2(DEPTH):0] count,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic full, do_push, do_pop;
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d = clr ? '0 : wp_q + (AW+1)'(do_push);
    rp_d = clr ? '0 : rp_q + (AW+1)'(do_pop);
    count = wp_q - rp_q;
    head = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/inst_order_merge.sv
// inst_order_merge: releases two fetch ways' results in pID order (clk, reset, bus: way inputs/readies, flush, decode output, order_err)
module inst_order_merge
  import inst_order_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  inst_order_merge_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_entry_t din [2];
  fetch_entry_t head [2];
  fetch_entry_t hd, out_q, out_d;
  logic [CW-1:0] count [2];
  logic [1:0] empty, push, pop;
  logic [PID_W-1:0] expect_q, expect_d;
  logic valid_q, valid_d, err_q, err_d, src, head_ok, load;
  for (genvar w = 0; w < 2; w++) begin : g_way
    order_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .clr(bus.flush_i),
      .push(push[w]), .pop(pop[w]), .din(din[w]),
      .head(head[w]), .count(count[w]), .empty(empty[w])
    );
  end
  always_comb begin
    din[0] = '{inst: bus.inst_way0_i, addr: bus.addr_way0_i, pid: bus.pid_way0_i};
    din[1] = '{inst: bus.inst_way1_i, addr: bus.addr_way1_i, pid: bus.pid_way1_i};
    push = {bus.valid_way1_i, bus.valid_way0_i} & {2{!bus.flush_i}};
    src = expect_q[0];
    hd = head[src];
    head_ok = !empty[src] && hd.pid == expect_q;
    load = head_ok && (!valid_q || bus.ready_i) && !bus.flush_i;
    pop = {load && src, load && !src};
    valid_d = bus.flush_i ? 1'b0 : load ? 1'b1 : bus.ready_i ? 1'b0 : valid_q;
    out_d = load ? hd : out_q;
    expect_d = bus.flush_i ? bus.flush_pid_i : expect_q + PID_W'(load);
    err_d = !bus.flush_i && !empty[src] && hd.pid != expect_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q <= '0;
      expect_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      out_q <= out_d;
      expect_q <= expect_d;
      err_q <= err_d;
    end
  end
  assign bus.ready_way0_o = count[0] <= CW'(DEPTH - 2);
  assign bus.ready_way1_o = count[1] <= CW'(DEPTH - 2);
  assign bus.valid_o = valid_q;
  assign bus.inst_o = out_q.inst;
  assign bus.addr_o = out_q.addr;
  assign bus.pid_o = out_q.pid;
  assign bus.order_err_o = err_q;
endmodule

// File: tb/tb_inst_order_merge.sv
// tb_inst_order_merge: directed stimulus with a scoreboard queue checked by an output monitor
module tb_inst_order_merge;
  import inst_order_merge_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  fetch_entry_t exp_q[$];
  always #5 clk = ~clk;
  inst_order_merge_if bus();
  inst_order_merge #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [31:0] addr_of(input logic [31:0] i);
    return i + 32'h0000_1000;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [1:0] p0, input logic [31:0] i0,
                       input logic v1, input logic [1:0] p1, input logic [31:0] i1);
    bus.valid_way0_i = v0; bus.pid_way0_i = p0; bus.inst_way0_i = i0; bus.addr_way0_i = addr_of(i0);
    bus.valid_way1_i = v1; bus.pid_way1_i = p1; bus.inst_way1_i = i1; bus.addr_way1_i = addr_of(i1);
    tick();
    bus.valid_way0_i = 1'b0;
    bus.valid_way1_i = 1'b0;
  endtask
  task automatic expect_out(input logic [31:0] i, input logic [1:0] p);
    exp_q.push_back('{inst: i, addr: addr_of(i), pid: p});
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!reset && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pid %0d inst %0h want no output", bus.pid_o, bus.inst_o);
      end else begin
        check("out_inst", bus.inst_o, exp_q[0].inst);
        check("out_addr", bus.addr_o, exp_q[0].addr);
        check("out_pid", bus.pid_o, exp_q[0].pid);
        if (bus.ready_i) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.valid_way0_i = 0; bus.valid_way1_i = 0; bus.flush_i = 0; bus.flush_pid_i = 0; bus.ready_i = 0;
    bus.inst_way0_i = 0; bus.inst_way1_i = 0; bus.addr_way0_i = 0; bus.addr_way1_i = 0;
    bus.pid_way0_i = 0; bus.pid_way1_i = 0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", bus.valid_o, 0);
    check("rst_inst", bus.inst_o, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_pid", bus.pid_o, 0);
    check("rst_err", bus.order_err_o, 0);
    check("rst_ready0", bus.ready_way0_o, 1);
    check("rst_ready1", bus.ready_way1_o, 1);
    // in-order stream, one per cycle
    bus.ready_i = 1'b1;
    expect_out(32'hA, 0); expect_out(32'hB, 1); expect_out(32'hC, 2); expect_out(32'hD, 3);
    drive(1, 0, 32'hA, 1, 1, 32'hB);
    drive(1, 2, 32'hC, 1, 3, 32'hD);
    drain("inorder_drain", 4);
    // pid1 arrives early and waits for pid0
    expect_out(32'h100, 0); expect_out(32'h101, 1);
    drive(0, 0, 0, 1, 1, 32'h101);
    for (int k = 0; k < 3; k++) begin
      check("early_valid", bus.valid_o, 0);
      check("early_err", bus.order_err_o, 0);
      tick();
    end
    drive(1, 0, 32'h100, 0, 0, 0);
    drain("early_drain", 3);
    // stall with four per way
    bus.ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_out(32'h200 + k, 2'(2 + 2 * k));
      expect_out(32'h300 + k, 2'(3 + 2 * k));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(2 + 2 * k), 32'h200 + k, 1, 2'(3 + 2 * k), 32'h300 + k);
      if (k == 2) begin
        check("stall_ready0_cnt2", bus.ready_way0_o, 1);
        check("stall_ready1_cnt3", bus.ready_way1_o, 0);
      end
    end
    check("stall_ready0_cnt3", bus.ready_way0_o, 0);
    check("stall_ready1_full", bus.ready_way1_o, 0);
    check("stall_valid", bus.valid_o, 1);
    for (int k = 0; k < 3; k++) tick();
    bus.ready_i = 1'b1;
    drain("stall_drain", 12);
    check("stall_ready0_after", bus.ready_way0_o, 1);
    check("stall_ready1_after", bus.ready_way1_o, 1);
    // long run wrapping pids and pointers
    begin
      int i0 = 0, i1 = 0, n = 0;
      logic v0, v1;
      for (int k = 0; k < 10; k++) begin
        expect_out(32'h400 + k, 2'(2 + 2 * k));
        expect_out(32'h500 + k, 2'(3 + 2 * k));
      end
      while ((i0 < 10 || i1 < 10) && n < 100) begin
        v0 = bus.ready_way0_o && i0 < 10;
        v1 = bus.ready_way1_o && i1 < 10;
        drive(v0, 2'(2 + 2 * i0), 32'h400 + i0, v1, 2'(3 + 2 * i1), 32'h500 + i1);
        if (v0) i0++;
        if (v1) i1++;
        n++;
      end
      check("long_sent0", i0, 10);
      check("long_sent1", i1, 10);
      drain("long_drain", 20);
    end
    // flush while an output is held and both FIFOs hold entries
    bus.ready_i = 1'b0;
    expect_out(32'h600, 2);
    drive(1, 2, 32'h600, 1, 3, 32'h601);
    drive(1, 0, 32'h602, 1, 1, 32'h603);
    tick();
    check("pre_flush_valid", bus.valid_o, 1);
    bus.flush_i = 1'b1; bus.flush_pid_i = 2;
    bus.valid_way0_i = 1'b1; bus.pid_way0_i = 2; bus.inst_way0_i = 32'h6FF; bus.addr_way0_i = addr_of(32'h6FF);
    tick();
    bus.flush_i = 1'b0; bus.valid_way0_i = 1'b0;
    exp_q.delete();
    check("flush_valid", bus.valid_o, 0);
    check("flush_ready0", bus.ready_way0_o, 1);
    check("flush_ready1", bus.ready_way1_o, 1);
    bus.ready_i = 1'b1;
    expect_out(32'h700, 2); expect_out(32'h701, 3);
    drive(1, 2, 32'h700, 1, 3, 32'h701);
    drain("flush_drain", 4);
    // wrong pid at the expected head
    drive(1, 2, 32'h800, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("err_pulse", bus.order_err_o, 1);
      check("err_valid", bus.valid_o, 0);
      tick();
    end
    bus.flush_i = 1'b1; bus.flush_pid_i = 0;
    tick();
    bus.flush_i = 1'b0;
    check("err_cleared", bus.order_err_o, 0);
    check("err_flush_valid", bus.valid_o, 0);
    expect_out(32'h900, 0);
    drive(1, 0, 32'h900, 0, 0, 0);
    drain("recover_drain", 3);
    check("recover_err", bus.order_err_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
